// File: rtl/corevx_ptw.sv
// Sv32 page table walker refilling corevx_tlb over a single-outstanding PTE read port.
// Optional macro COREVX_PTW_MEGAPAGE_EN: accept level-1 leaves as 4 MiB megapages.
module corevx_ptw #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        resolve_request,
  input  logic [19:0] virtual_address,
  input  logic [21:0] satp_ppn,
  output logic        mem_read,
  output logic [33:0] mem_address,
  input  logic        mem_done,
  input  logic        mem_error,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        pagefault,
  output logic        accessfault,
  output logic        write,
  output logic [19:0] virtual_address_w,
  output logic [21:0] phys_w,
  output logic [7:0]  accesstag_w
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic        level;
  logic [15:0] wait_count;

  logic pte_v, pte_r, pte_w, pte_x;
  logic unused_rsw;

  assign pte_v      = mem_rdata[0];
  assign pte_r      = mem_rdata[1];
  assign pte_w      = mem_rdata[2];
  assign pte_x      = mem_rdata[3];
  assign unused_rsw = ^mem_rdata[9:8];

  // rst_n is active-high here, so it is used directly as the async set of IDLE.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state             <= IDLE;
      level             <= 1'b0;
      wait_count        <= '0;
      mem_read          <= 1'b0;
      mem_address       <= '0;
      done              <= 1'b0;
      pagefault         <= 1'b0;
      accessfault       <= 1'b0;
      write             <= 1'b0;
      virtual_address_w <= '0;
      phys_w            <= '0;
      accesstag_w       <= '0;
    end else begin
      mem_read <= 1'b0;
      done     <= 1'b0;
      write    <= 1'b0;
      case (state)
        IDLE: begin
          if (resolve_request) begin
            virtual_address_w <= virtual_address;
            level             <= 1'b1;
            mem_address       <= {satp_ppn, virtual_address[19:10], 2'b00};
            pagefault         <= 1'b0;
            accessfault       <= 1'b0;
            mem_read          <= 1'b1;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          wait_count <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (mem_done) begin
            done  <= 1'b1;
            state <= IDLE;
            if (mem_error) begin
              accessfault <= 1'b1;
            end else if (!pte_v || (!pte_r && pte_w)) begin
              pagefault <= 1'b1;
            end else if (!pte_r && !pte_x) begin
              // Pointer PTE: only legal from the root table, descend one level.
              if (level) begin
                done        <= 1'b0;
                level       <= 1'b0;
                mem_address <= {mem_rdata[31:10], virtual_address_w[9:0], 2'b00};
                mem_read    <= 1'b1;
                state       <= ISSUE;
              end else begin
                pagefault <= 1'b1;
              end
            end else if (!level) begin
              phys_w      <= mem_rdata[31:10];
              accesstag_w <= mem_rdata[7:0];
              write       <= 1'b1;
            end else begin
`ifdef COREVX_PTW_MEGAPAGE_EN
              if (mem_rdata[19:10] != 10'd0) begin
                pagefault <= 1'b1;
              end else begin
                phys_w      <= {mem_rdata[31:20], virtual_address_w[9:0]};
                accesstag_w <= mem_rdata[7:0];
                write       <= 1'b1;
              end
`else
              pagefault <= 1'b1;
`endif
            end
          end else if ((TIMEOUT_CYCLES != 0) && (wait_count == TIMEOUT_LIMIT)) begin
            done        <= 1'b1;
            accessfault <= 1'b1;
            state       <= IDLE;
          end else begin
            wait_count <= wait_count + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corevx_ptw.sv
// Randomized self-checking bench for corevx_ptw against a behavioural Sv32 walk model.
// Honours COREVX_PTW_MEGAPAGE_EN the same way the design does.
module tb_corevx_ptw;

  localparam int unsigned TIMEOUT = 4;
`ifdef COREVX_PTW_MEGAPAGE_EN
  localparam bit MEGA = 1'b1;
`else
  localparam bit MEGA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        resolve_request;
  logic [19:0] virtual_address;
  logic [21:0] satp_ppn;
  logic        mem_read;
  logic [33:0] mem_address;
  logic        mem_done;
  logic        mem_error;
  logic [31:0] mem_rdata;
  logic        done;
  logic        pagefault;
  logic        accessfault;
  logic        write;
  logic [19:0] virtual_address_w;
  logic [21:0] phys_w;
  logic [7:0]  accesstag_w;

  int checks = 0;
  int passes = 0;

  corevx_ptw #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .resolve_request(resolve_request),
    .virtual_address(virtual_address), .satp_ppn(satp_ppn),
    .mem_read(mem_read), .mem_address(mem_address), .mem_done(mem_done),
    .mem_error(mem_error), .mem_rdata(mem_rdata), .done(done),
    .pagefault(pagefault), .accessfault(accessfault), .write(write),
    .virtual_address_w(virtual_address_w), .phys_w(phys_w), .accesstag_w(accesstag_w)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
  endtask

  // Random PTE biased towards pointers and valid leaves, with some faulting encodings.
  function automatic logic [31:0] randPte();
    logic [31:0] p;
    p = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: p[3:0] = 4'b0001;
      4, 5: begin
        case ($urandom_range(0, 3))
          0: p[3:0] = 4'b0011;
          1: p[3:0] = 4'b1001;
          2: p[3:0] = 4'b1011;
          default: p[3:0] = 4'b0111;
        endcase
      end
      6: p[0] = 1'b0;
      7: p[3:0] = {p[3], 3'b101};
      8: begin
        p[3:0] = 4'b1011;
        p[19:10] = 10'd0;
      end
      default: ;
    endcase
    return p;
  endfunction

  // One walk: model the expected outcome, then act as memory and compare each step.
  task automatic applyStimulus(input logic [21:0] satp, input logic [19:0] va,
                               input logic [31:0] pte_a, input logic [31:0] pte_b,
                               input logic err_a, input logic err_b,
                               input int dly_a, input int dly_b, input bit poke);
    logic [31:0] ptes [2];
    logic        errs [2];
    int          dlys [2];
    logic [33:0] exp_addr [2];
    logic [33:0] table_base;
    logic [31:0] p;
    logic [9:0]  idx;
    logic [21:0] exp_phys;
    logic [7:0]  exp_tag;
    int          exp_reads;
    int          exp_kind;
    ptes[0] = pte_a; ptes[1] = pte_b;
    errs[0] = err_a; errs[1] = err_b;
    dlys[0] = dly_a; dlys[1] = dly_b;
    exp_addr[0] = '0; exp_addr[1] = '0;
    exp_phys = '0; exp_tag = '0;
    exp_reads = 0; exp_kind = -1;
    table_base = 34'(satp) * 34'd4096;
    for (int lvl = 1; lvl >= 0 && exp_kind < 0; lvl--) begin
      idx = (lvl == 1) ? va[19:10] : va[9:0];
      exp_addr[exp_reads] = table_base + 34'(idx) * 34'd4;
      p = ptes[exp_reads];
      exp_reads++;
      if (errs[exp_reads-1]) exp_kind = 2;
      else if (!p[0] || (p[2] && !p[1])) exp_kind = 1;
      else if (p[1] || p[3]) begin
        exp_tag = p[7:0];
        if (lvl == 0) begin
          exp_kind = 0;
          exp_phys = p[31:10];
        end else if (MEGA && p[19:10] == 10'd0) begin
          exp_kind = 0;
          exp_phys = 22'(p[31:20]) * 22'd1024 + 22'(va[9:0]);
        end else exp_kind = 1;
      end else if (lvl == 0) exp_kind = 1;
      else table_base = 34'(p[31:10]) * 34'd4096;
    end

    resolve_request = 1'b1;
    virtual_address = va;
    satp_ppn = satp;
    step();
    resolve_request = 1'b0;
    virtual_address = 20'($urandom);
    satp_ppn = 22'($urandom);
    checkOutput("done_pulse", done, 0);
    for (int r = 0; r < exp_reads; r++) begin
      checkOutput("mem_read", mem_read, 1);
      checkOutput("mem_address", mem_address, exp_addr[r]);
      step();
      checkOutput("read_pulse", mem_read, 0);
      for (int c = 0; c < dlys[r]; c++) begin
        resolve_request = poke;
        step();
        checkOutput("wait_quiet", done | mem_read, 0);
      end
      resolve_request = 1'b0;
      mem_done = 1'b1;
      mem_error = errs[r];
      mem_rdata = ptes[r];
      step();
      mem_done = 1'b0;
      mem_error = 1'($urandom);
      mem_rdata = $urandom;
      if (r < exp_reads - 1) checkOutput("walk_continue", done, 0);
    end
    checkOutput("done", done, 1);
    checkOutput("write", write, exp_kind == 0);
    checkOutput("pagefault", pagefault, exp_kind == 1);
    checkOutput("accessfault", accessfault, exp_kind == 2);
    checkOutput("va_w", virtual_address_w, va);
    if (exp_kind == 0) begin
      checkOutput("phys_w", phys_w, exp_phys);
      checkOutput("accesstag_w", accesstag_w, exp_tag);
    end
  endtask

  initial begin
    int cycles;
    rst_n = 1'b1;
    resolve_request = 1'b0;
    virtual_address = '0;
    satp_ppn = '0;
    mem_done = 1'b0;
    mem_error = 1'b0;
    mem_rdata = '0;
    repeat (3) step();
    checkOutput("reset_outputs", {mem_read, done, write, pagefault, accessfault}, 0);
    checkOutput("reset_addr", mem_address, 0);
    checkOutput("reset_result", {phys_w, accesstag_w, virtual_address_w}, 0);
    rst_n = 1'b0;
    step();

    // Directed walks from the reference scenarios.
    applyStimulus(22'h100, 20'h2_0001, 32'h0004_0001, 32'h0400_00CF, 0, 0, 0, 0, 0);
    applyStimulus(22'h100, 20'h2_0001, 32'h0000_0000, 32'h0, 0, 0, 0, 0, 0);
    applyStimulus(22'h155, 20'h3_1234, 32'h0004_0001, 32'h0004_0001, 0, 0, 1, 1, 1);
    applyStimulus(22'h155, 20'h3_1234, 32'h0004_0001, 32'h0000_0005, 0, 0, 2, 0, 0);
    applyStimulus(22'h0AA, 20'h0_0F0F, 32'h0004_0001, 32'h0, 1, 0, 0, 0, 0);
    applyStimulus(22'h100, 20'h2_0001, 32'h2000_00CF, 32'h0, 0, 0, 0, 0, 0);
    applyStimulus(22'h100, 20'h2_0001, 32'h2000_04CF, 32'h0, 0, 0, 0, 0, 0);

    // Timeout: no response, fault expected five cycles after entering WAIT.
    resolve_request = 1'b1;
    virtual_address = 20'h1_2345;
    satp_ppn = 22'h3_0000;
    step();
    resolve_request = 1'b0;
    step();
    cycles = 0;
    while (!done && cycles < 20) begin
      step();
      cycles++;
    end
    checkOutput("timeout_cycles", cycles, 5);
    checkOutput("timeout_fault", {accessfault, pagefault, write}, 3'b100);
    mem_done = 1'b1;
    mem_rdata = 32'h0400_00CF;
    mem_error = 1'b0;
    step();
    mem_done = 1'b0;
    step();
    checkOutput("late_done_ignored", {done, write, mem_read}, 0);

    // Reset in the middle of a walk.
    resolve_request = 1'b1;
    virtual_address = 20'hA_BCDE;
    satp_ppn = 22'h2_2222;
    step();
    resolve_request = 1'b0;
    step();
    step();
    #2 rst_n = 1'b1;
    #1;
    checkOutput("midwalk_reset_addr", mem_address, 0);
    checkOutput("midwalk_reset_flags", {mem_read, done, write, pagefault, accessfault}, 0);
    checkOutput("midwalk_reset_va", virtual_address_w, 0);
    rst_n = 1'b0;
    mem_done = 1'b1;
    mem_rdata = 32'h0400_00CF;
    step();
    mem_done = 1'b0;
    step();
    checkOutput("post_reset_quiet", {done, write, mem_read}, 0);

    // Randomized walks, mostly back-to-back with occasional idle gaps.
    for (int n = 0; n < 80; n++) begin
      applyStimulus(22'($urandom), 20'($urandom), randPte(), randPte(),
                    $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
